// File: rtl/vend_change_controller.sv
// Vending-machine change controller.
// Accepts a purchase against the upstream credit total, checks the price,
// releases the product and pays change one coin per cycle, largest coin
// first, from a snapshot of the coin inventory taken when the purchase is
// approved.
//
// Handshake: purchase is a level sampled only while busy is low (IDLE);
// busy high means the request is not accepted. done pulses once per
// accepted purchase, and clear_credit pulses only when the product was
// actually released.
module vend_change_controller #(
    parameter int VAL_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             purchase,
    input  logic [VAL_W-1:0] credit,
    input  logic [VAL_W-1:0] price,
    input  logic [CNT_W-1:0] inv_500,
    input  logic [CNT_W-1:0] inv_1000,
    input  logic [CNT_W-1:0] inv_2000,
    input  logic [CNT_W-1:0] inv_5000,
    output logic             busy,
    output logic             dispense,
    output logic [3:0]       coin_out,
    output logic [VAL_W-1:0] change_left,
    output logic             clear_credit,
    output logic             done,
    output logic [3:0]       error,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        FINISH   = 3'd4,
        FAIL     = 3'd5
    } state_t;

    localparam logic [VAL_W-1:0] D500  = VAL_W'(500);
    localparam logic [VAL_W-1:0] D1000 = VAL_W'(1000);
    localparam logic [VAL_W-1:0] D2000 = VAL_W'(2000);
    localparam logic [VAL_W-1:0] D5000 = VAL_W'(5000);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [VAL_W-1:0] credit_l, credit_l_n;
    logic [VAL_W-1:0] price_l, price_l_n;
    logic [CNT_W-1:0] cnt_500, cnt_500_n;
    logic [CNT_W-1:0] cnt_1000, cnt_1000_n;
    logic [CNT_W-1:0] cnt_2000, cnt_2000_n;
    logic [CNT_W-1:0] cnt_5000, cnt_5000_n;
    logic             busy_n;
    logic             dispense_n;
    logic [3:0]       coin_out_n;
    logic [VAL_W-1:0] change_left_n;
    logic             clear_credit_n;
    logic             done_n;
    logic [3:0]       error_n;
    logic             picked;

    assign state_dbg = state;

    // Register the state, the transaction snapshot and every output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            credit_l     <= '0;
            price_l      <= '0;
            cnt_500      <= '0;
            cnt_1000     <= '0;
            cnt_2000     <= '0;
            cnt_5000     <= '0;
            busy         <= 1'b0;
            dispense     <= 1'b0;
            coin_out     <= 4'b0000;
            change_left  <= '0;
            clear_credit <= 1'b0;
            done         <= 1'b0;
            error        <= 4'b0000;
        end else begin
            state        <= state_n;
            credit_l     <= credit_l_n;
            price_l      <= price_l_n;
            cnt_500      <= cnt_500_n;
            cnt_1000     <= cnt_1000_n;
            cnt_2000     <= cnt_2000_n;
            cnt_5000     <= cnt_5000_n;
            busy         <= busy_n;
            dispense     <= dispense_n;
            coin_out     <= coin_out_n;
            change_left  <= change_left_n;
            clear_credit <= clear_credit_n;
            done         <= done_n;
            error        <= error_n;
        end
    end

    // Next-state and next-output decode; pulses default low, values hold.
    always_comb begin
        state_n        = state;
        credit_l_n     = credit_l;
        price_l_n      = price_l;
        cnt_500_n      = cnt_500;
        cnt_1000_n     = cnt_1000;
        cnt_2000_n     = cnt_2000;
        cnt_5000_n     = cnt_5000;
        dispense_n     = 1'b0;
        coin_out_n     = 4'b0000;
        change_left_n  = change_left;
        clear_credit_n = 1'b0;
        done_n         = 1'b0;
        error_n        = error;
        picked         = 1'b0;

        case (state)
            IDLE: begin
                if (purchase) begin
                    error_n       = 4'b0000;
                    change_left_n = '0;
                    credit_l_n    = credit;
                    price_l_n     = price;
                    state_n       = CHECK;
                end
            end
            CHECK: begin
                if (price_l == '0) begin
                    error_n = 4'b0001;
                    state_n = FAIL;
                end else if (credit_l < price_l) begin
                    error_n = 4'b0010;
                    state_n = FAIL;
                end else begin
                    // Inventory is frozen here; later inv_* changes are ignored.
                    change_left_n = credit_l - price_l;
                    cnt_500_n     = inv_500;
                    cnt_1000_n    = inv_1000;
                    cnt_2000_n    = inv_2000;
                    cnt_5000_n    = inv_5000;
                    state_n       = DISPENSE;
                end
            end
            DISPENSE: begin
                dispense_n = 1'b1;
                state_n    = CHANGE;
            end
            CHANGE: begin
                if (change_left == '0) begin
                    state_n = FINISH;
                end else if (change_left >= D5000 && cnt_5000 != '0) begin
                    coin_out_n    = 4'b1000;
                    change_left_n = change_left - D5000;
                    cnt_5000_n    = cnt_5000 - CNT_ONE;
                    picked        = 1'b1;
                end else if (change_left >= D2000 && cnt_2000 != '0) begin
                    coin_out_n    = 4'b0100;
                    change_left_n = change_left - D2000;
                    cnt_2000_n    = cnt_2000 - CNT_ONE;
                    picked        = 1'b1;
                end else if (change_left >= D1000 && cnt_1000 != '0) begin
                    coin_out_n    = 4'b0010;
                    change_left_n = change_left - D1000;
                    cnt_1000_n    = cnt_1000 - CNT_ONE;
                    picked        = 1'b1;
                end else if (change_left >= D500 && cnt_500 != '0) begin
                    coin_out_n    = 4'b0001;
                    change_left_n = change_left - D500;
                    cnt_500_n     = cnt_500 - CNT_ONE;
                    picked        = 1'b1;
                end else begin
                    // Owed amount cannot be paid: report it and keep the balance.
                    error_n = 4'b0100;
                    state_n = FINISH;
                end
                // Leave straight after the last coin so done follows one cycle later.
                if (picked && change_left_n == '0) begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                done_n         = 1'b1;
                clear_credit_n = 1'b1;
                state_n        = IDLE;
            end
            FAIL: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_vend_change_controller.sv
// Self-checking bench for vend_change_controller: directed purchases,
// error paths, mid-transaction reset and a few randomized purchases.
module tb_vend_change_controller;

    logic        clock;
    logic        reset;
    logic        purchase;
    logic [15:0] credit;
    logic [15:0] price;
    logic [7:0]  inv_500;
    logic [7:0]  inv_1000;
    logic [7:0]  inv_2000;
    logic [7:0]  inv_5000;
    logic        busy;
    logic        dispense;
    logic [3:0]  coin_out;
    logic [15:0] change_left;
    logic        clear_credit;
    logic        done;
    logic [3:0]  error;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];

    vend_change_controller #(.VAL_W(16), .CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .purchase     (purchase),
        .credit       (credit),
        .price        (price),
        .inv_500      (inv_500),
        .inv_1000     (inv_1000),
        .inv_2000     (inv_2000),
        .inv_5000     (inv_5000),
        .busy         (busy),
        .dispense     (dispense),
        .coin_out     (coin_out),
        .change_left  (change_left),
        .clear_credit (clear_credit),
        .done         (done),
        .error        (error),
        .state_dbg    (state_dbg)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drives one purchase starting at the current (negedge) time and checks
    // the whole transaction. Expected coins must already be in exp_q.
    // ok = purchase expected to pass the price check (product released).
    // poke = pulse purchase again mid-transaction; it must be ignored.
    task automatic run_txn(input string name,
                           input logic [15:0] cr, input logic [15:0] pr,
                           input logic [7:0] i500, input logic [7:0] i1000,
                           input logic [7:0] i2000, input logic [7:0] i5000,
                           input logic [3:0] exp_err, input logic [15:0] exp_left,
                           input bit ok, input bit poke);
        int cyc;
        int n_disp;
        int n_clear;
        int disp_c;
        int first_coin;
        int n_exp;
        bit done_seen;
        logic [3:0] exp_coin;
        n_exp      = exp_q.size();
        n_disp     = 0;
        n_clear    = 0;
        disp_c     = -1;
        first_coin = -1;
        done_seen  = 1'b0;
        credit   = cr;
        price    = pr;
        inv_500  = i500;
        inv_1000 = i1000;
        inv_2000 = i2000;
        inv_5000 = i5000;
        purchase = 1'b1;
        @(posedge clock);
        @(negedge clock);
        purchase = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
        end
        cyc = 0;
        while (!done_seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            // Snapshot was taken at the CHECK edge; wiping inventory now must not matter.
            if (cyc == 1) begin
                inv_500  = 8'd0;
                inv_1000 = 8'd0;
                inv_2000 = 8'd0;
                inv_5000 = 8'd0;
            end
            if (poke && cyc == 2) purchase = 1'b1;
            if (poke && cyc == 3) purchase = 1'b0;
            if (dispense === 1'b1) begin
                n_disp++;
                disp_c = cyc;
            end
            if (clear_credit === 1'b1) n_clear++;
            if (coin_out !== 4'b0000) begin
                if (first_coin < 0) first_coin = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s coin_unexpected: got %b expected 0000", name, coin_out);
                end else begin
                    exp_coin = exp_q.pop_front();
                    if (coin_out !== exp_coin) begin
                        errors++;
                        $display("FAIL %s coin: got %b expected %b", name, coin_out, exp_coin);
                    end
                end
            end
            if (done === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s done_timeout: got no done expected done within 40 cycles", name);
        end
        checks++;
        if (error !== exp_err) begin
            errors++;
            $display("FAIL %s error: got %b expected %b", name, error, exp_err);
        end
        checks++;
        if (change_left !== exp_left) begin
            errors++;
            $display("FAIL %s change_left: got %0d expected %0d", name, change_left, exp_left);
        end
        checks++;
        if (n_disp !== (ok ? 1 : 0)) begin
            errors++;
            $display("FAIL %s dispense_count: got %0d expected %0d", name, n_disp, ok ? 1 : 0);
        end
        checks++;
        if (n_clear !== (ok ? 1 : 0)) begin
            errors++;
            $display("FAIL %s clear_credit_count: got %0d expected %0d", name, n_clear, ok ? 1 : 0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s coins_missing: got %0d left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        if (ok) begin
            checks++;
            if (disp_c != 2) begin
                errors++;
                $display("FAIL %s dispense_latency: got %0d expected 2", name, disp_c);
            end
        end
        if (n_exp > 0) begin
            checks++;
            if (first_coin != 3) begin
                errors++;
                $display("FAIL %s first_coin_latency: got %0d expected 3", name, first_coin);
            end
        end
        repeat (2) begin
            @(negedge clock);
            checks++;
            if ({busy, done, clear_credit, dispense, coin_out} !== 8'h00) begin
                errors++;
                $display("FAIL %s idle_after_done: got busy=%b done=%b clr=%b disp=%b coin=%b expected all 0",
                         name, busy, done, clear_credit, dispense, coin_out);
            end
        end
    endtask

    task automatic test_reset();
        purchase = 1'b0;
        credit   = 16'd0;
        price    = 16'd0;
        inv_500  = 8'd0;
        inv_1000 = 8'd0;
        inv_2000 = 8'd0;
        inv_5000 = 8'd0;
        reset    = 1'b1;
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, dispense, coin_out, change_left, clear_credit, done, error} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b disp=%b coin=%b left=%0d clr=%b done=%b err=%b expected all 0",
                     busy, dispense, coin_out, change_left, clear_credit, done, error);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_coin();
        exp_q.push_back(4'b0100);
        run_txn("single_coin", 16'd3500, 16'd1500, 8'd10, 8'd10, 8'd10, 8'd10,
                4'b0000, 16'd0, 1'b1, 1'b0);
    endtask

    task automatic test_multi_coin();
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
        run_txn("multi_coin", 16'd8500, 16'd500, 8'd10, 8'd10, 8'd10, 8'd10,
                4'b0000, 16'd0, 1'b1, 1'b1);
    endtask

    task automatic test_insufficient();
        run_txn("insufficient", 16'd1000, 16'd1500, 8'd10, 8'd10, 8'd10, 8'd10,
                4'b0010, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_invalid();
        run_txn("invalid_product", 16'd2000, 16'd0, 8'd10, 8'd10, 8'd10, 8'd10,
                4'b0001, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_shortfall();
        exp_q.push_back(4'b0001);
        run_txn("shortfall", 16'd2000, 16'd500, 8'd1, 8'd0, 8'd5, 8'd10,
                4'b0100, 16'd1000, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        credit   = 16'd8500;
        price    = 16'd500;
        inv_500  = 8'd10;
        inv_1000 = 8'd10;
        inv_2000 = 8'd10;
        inv_5000 = 8'd10;
        purchase = 1'b1;
        @(posedge clock);
        @(negedge clock);
        purchase = 1'b0;
        for (cyc = 1; cyc <= 3; cyc++) @(negedge clock);
        checks++;
        if (coin_out !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_first_coin: got %b expected 1000", coin_out);
        end
        // Second CHANGE cycle: pull reset asynchronously.
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, dispense, coin_out, change_left, clear_credit, done, error} !== 28'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b disp=%b coin=%b left=%0d clr=%b done=%b err=%b expected all 0",
                     busy, dispense, coin_out, change_left, clear_credit, done, error);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_state: got %0d expected 0", state_dbg);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if ({busy, dispense, coin_out, done, clear_credit} !== 8'h00) begin
                errors++;
                $display("FAIL reset_mid_no_resume: got busy=%b disp=%b coin=%b done=%b clr=%b expected all 0",
                         busy, dispense, coin_out, done, clear_credit);
            end
        end
        exp_q.push_back(4'b0100);
        run_txn("after_reset", 16'd3500, 16'd1500, 8'd10, 8'd10, 8'd10, 8'd10,
                4'b0000, 16'd0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] pr;
        logic [15:0] cr;
        logic [15:0] rem;
        // Exact change: product released, no coins.
        run_txn("exact_change", 16'd1500, 16'd1500, 8'd10, 8'd10, 8'd10, 8'd10,
                4'b0000, 16'd0, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            pr  = 16'(500 * $urandom_range(1, 10));
            cr  = pr + 16'(500 * $urandom_range(0, 20));
            rem = cr - pr;
            while (rem >= 16'd5000) begin exp_q.push_back(4'b1000); rem = rem - 16'd5000; end
            while (rem >= 16'd2000) begin exp_q.push_back(4'b0100); rem = rem - 16'd2000; end
            while (rem >= 16'd1000) begin exp_q.push_back(4'b0010); rem = rem - 16'd1000; end
            while (rem >= 16'd500)  begin exp_q.push_back(4'b0001); rem = rem - 16'd500;  end
            run_txn("random", cr, pr, 8'd10, 8'd10, 8'd10, 8'd10,
                    4'b0000, 16'd0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single_coin();
        test_multi_coin();
        test_insufficient();
        test_invalid();
        test_shortfall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
